upct: RTL and testbench
=======================

Name: upct

Overview:
- Upper PC table for the fetch predictor. Stores full upper target bits once; BTB entries keep only a 10-bit target slice plus a small index into this table.
- Two ends of the same interface:
  - Update end (encoder): takes a resolved full target PC and returns an index, allocating an entry on a miss.
  - Read end (decoder): takes an index from a BTB hit and returns the upper PC bits.
- Sits beside the BTB; reads come from the fetch predict stage, updates from the branch-update path.

Parameters:
UPPER_PC_TABLE_ENTRIES, 8, number of table entries; must be a power of 2.
LOG_UPPER_PC_TABLE_ENTRIES, $clog2(UPPER_PC_TABLE_ENTRIES), index width.
UPPER_PC_WIDTH, 21, stored upper bits, equal to 32 - BTB_TARGET_WIDTH - 1 (PC[31:11]).

Ports:
CLK  input  1  clock
RST  input  1  async active-high reset
read_valid  input  1  fetch read request this cycle
read_index  input  LOG_UPPER_PC_TABLE_ENTRIES  index from BTB entry
read_upper_PC  output  UPPER_PC_WIDTH  upper PC for read issued last cycle
update0_valid  input  1  update request this cycle
update0_target_full_PC  input  32  resolved target PC
update1_upper_PC_index  output  LOG_UPPER_PC_TABLE_ENTRIES  index for update issued last cycle

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous, active-high.
- Reset state: all entries 0, all valid bits 0, PLRU tree bits 0, read_upper_PC = 0, update1_upper_PC_index = 0.
- Read path:
  - Latency is 1 cycle: read_upper_PC <= array[read_index] when read_valid; otherwise it holds its value.
  - No valid check: an invalid entry returns its stored value.
  - A read with read_valid touches read_index in the PLRU.
- Update path, 2-stage (update0 compare/alloc, update1 output):
  - upper = update0_target_full_PC[31:11].
  - Compare against all entries; hit requires valid & tag equal. Multiple hits are impossible by construction; if forced, the lowest index wins.
  - Hit: index = hit index; no array write.
  - Miss: victim = lowest-index invalid entry if any, otherwise the PLRU victim. At clock edge write array[victim] = upper, valid[victim] = 1. index = victim.
  - update1_upper_PC_index <= index when update0_valid; otherwise it holds.
  - The update touches index in the PLRU.
- PLRU: binary tree, UPPER_PC_TABLE_ENTRIES-1 bits.
  - Touch sets the path bits to point away from the entry.
  - Victim follows the bits.
  - Read and update in the same cycle: apply the read touch first, then the update touch; the update wins on shared tree bits.
- Back-to-back updates with the same new upper in cycles N and N+1: the N+1 update hits the entry allocated in N and returns the same index. No duplicate allocation.
- Read of an index being written by an update miss in the same cycle: returns the old array value (read-before-write), unless the optional feature below is enabled.
- RST mid-operation: clears the table immediately; the pending update1 output is lost and returns 0.
- No backpressure: both ports accept one request per cycle, always.

Optional Feature:
- Macro: UPCT_READ_BYPASS_EN.
- Defined: if read_valid and an update0 miss writes victim == read_index in the same cycle, read_upper_PC gets the new upper.
- Undefined: read_upper_PC gets the old stored value.

Decomposition:
- Shared package core_types_pkg:
  - UPPER_PC_TABLE_ENTRIES
  - UPPER_PC_WIDTH
  - new LOG_UPPER_PC_TABLE_ENTRIES
  - typedef upper_PC_t (logic [UPPER_PC_WIDTH-1:0])
  - typedef upct_idx_t
- Natural sub-module: plru_updater, parameterized by entry count.
  - Inputs: current tree bits, touch index.
  - Outputs: new tree bits, victim index.
  - Instantiated twice (read touch, then update touch) chained combinationally.

Test Plan:
- After reset, update0 PC=0x0000_0800 (upper 0x000001) -> next cycle index 0; a read of index 0 two cycles later returns 0x000001.
- Updates with PCs 0x0000_0800 + k*0x800, k=0..7 -> indices 0..7 in order; repeating PC 0x0000_1000 -> index 1 with no write (array unchanged).
- Table full, then touch indices 0..6 via reads, then update with new upper 0x1FFFFF -> allocates index 7 (PLRU victim); read index 7 returns 0x1FFFFF.
- Same new PC 0xABCD_E800 on two consecutive update cycles -> both return the same index; only one entry holds 0x1579BD.
- Read index 3 in the same cycle as an update miss allocating 3 with upper 0x00ABCD -> old value without UPCT_READ_BYPASS_EN, 0x00ABCD with it.
- Assert RST while update1 is pending -> both outputs 0 immediately; next update re-allocates index 0.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared fetch-predictor types: upper PC table geometry and index/tag types.
package core_types_pkg;

  localparam int unsigned BTB_TARGET_WIDTH           = 10;
  localparam int unsigned UPPER_PC_TABLE_ENTRIES     = 8;
  localparam int unsigned LOG_UPPER_PC_TABLE_ENTRIES = $clog2(UPPER_PC_TABLE_ENTRIES);
  localparam int unsigned UPPER_PC_WIDTH             = 32 - BTB_TARGET_WIDTH - 1;
  localparam int unsigned UPPER_PC_LSB               = 32 - UPPER_PC_WIDTH;

  typedef logic [UPPER_PC_WIDTH-1:0]             upper_PC_t;
  typedef logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] upct_idx_t;

  // Upper PC bits stored in the table (PC[31:11]).
  function automatic upper_PC_t upper_of(input logic [31:0] pc);
    return pc[31:UPPER_PC_LSB];
  endfunction

endpackage

// File: rtl/upct_plru_updater.sv
// Combinational binary-tree PLRU step: touch an entry and report the victim.
// Tree is heap ordered (node n at bit n-1); a 0 bit points left, 1 points right.
// The victim is taken from the incoming tree bits, before the touch.
module plru_updater #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic [ENTRIES-2:0]         tree_bits,
  input  logic [$clog2(ENTRIES)-1:0] touch_index,
  output logic [ENTRIES-2:0]         new_tree_bits_c,
  output logic [$clog2(ENTRIES)-1:0] victim_index_c
);

  localparam int unsigned LOG = $clog2(ENTRIES);

  logic [LOG-1:0] touch_node;
  logic [LOG-1:0] touch_path;
  logic [LOG-1:0] victim_node;
  logic           touch_dir;
  logic           victim_dir;

  // Walk the touch path setting each node away from the entry, then follow bits for the victim.
  always_comb begin
    new_tree_bits_c = tree_bits;
    victim_index_c  = '0;
    touch_node      = LOG'(1);
    touch_path      = touch_index;
    victim_node     = LOG'(1);
    touch_dir       = 1'b0;
    victim_dir      = 1'b0;
    for (int l = 0; l < int'(LOG); l++) begin
      touch_dir                            = touch_path[LOG-1];
      new_tree_bits_c[touch_node - 1'b1]   = ~touch_dir;
      touch_node                           = {touch_node[LOG-2:0], touch_dir};
      touch_path                           = touch_path << 1;
    end
    for (int l = 0; l < int'(LOG); l++) begin
      victim_dir     = tree_bits[victim_node - 1'b1];
      victim_index_c = {victim_index_c[LOG-2:0], victim_dir};
      victim_node    = {victim_node[LOG-2:0], victim_dir};
    end
  end

endmodule

// File: rtl/upct.sv
// Upper PC table: dedups PC[31:11] for BTB targets; read (decode) and update (encode) ends.
// Optional: UPCT_READ_BYPASS_EN forwards a same-cycle miss allocation to the read port.
module upct
  import core_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        read_valid,
  input  upct_idx_t   read_index,
  output upper_PC_t   read_upper_PC,
  input  logic        update0_valid,
  input  logic [31:0] update0_target_full_PC,
  output upct_idx_t   update1_upper_PC_index
);

  localparam int unsigned N = UPPER_PC_TABLE_ENTRIES;

  upper_PC_t       upper_tbl [N];
  logic [N-1:0]    valid;
  logic [N-2:0]    plru;

  upper_PC_t       upd_upper_c;
  logic            upd_hit_c;
  upct_idx_t       hit_idx_c;
  logic            any_invalid_c;
  upct_idx_t       inv_idx_c;
  upct_idx_t       victim_c;
  upct_idx_t       upd_idx_c;
  upper_PC_t       rd_data_c;

  logic [N-2:0]    rd_tree_c;
  logic [N-2:0]    after_rd_tree_c;
  logic [N-2:0]    upd_tree_c;
  logic [N-2:0]    plru_next_c;
  upct_idx_t       rd_victim_c;
  upct_idx_t       upd_victim_c;

  logic            unused_pc_lsbs;

  assign upd_upper_c    = upper_of(update0_target_full_PC);
  assign unused_pc_lsbs = ^update0_target_full_PC[UPPER_PC_LSB-1:0];

  // Tag compare and lowest-index free entry; descending scan lets the lowest index win.
  always_comb begin
    upd_hit_c     = 1'b0;
    hit_idx_c     = '0;
    any_invalid_c = 1'b0;
    inv_idx_c     = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (valid[upct_idx_t'(i)] && (upper_tbl[upct_idx_t'(i)] == upd_upper_c)) begin
        upd_hit_c = 1'b1;
        hit_idx_c = upct_idx_t'(i);
      end
      if (!valid[upct_idx_t'(i)]) begin
        any_invalid_c = 1'b1;
        inv_idx_c     = upct_idx_t'(i);
      end
    end
  end

  // Read touch first, then update touch on the read-touched tree.
  plru_updater #(.ENTRIES(N)) u_rd_touch (
    .tree_bits       (plru),
    .touch_index     (read_index),
    .new_tree_bits_c (rd_tree_c),
    .victim_index_c  (rd_victim_c)
  );

  assign after_rd_tree_c = read_valid ? rd_tree_c : plru;

  plru_updater #(.ENTRIES(N)) u_upd_touch (
    .tree_bits       (after_rd_tree_c),
    .touch_index     (upd_idx_c),
    .new_tree_bits_c (upd_tree_c),
    .victim_index_c  (upd_victim_c)
  );

  // Update victim sees the read-touched tree; with no read both instances see the same tree.
  assign victim_c    = read_valid ? upd_victim_c : rd_victim_c;
  assign upd_idx_c   = upd_hit_c ? hit_idx_c : (any_invalid_c ? inv_idx_c : victim_c);
  assign plru_next_c = update0_valid ? upd_tree_c : after_rd_tree_c;

  // Read data: old stored value unless the same-cycle allocation is forwarded.
  always_comb begin
    rd_data_c = upper_tbl[read_index];
`ifdef UPCT_READ_BYPASS_EN
    if (update0_valid && !upd_hit_c && (upd_idx_c == read_index)) begin
      rd_data_c = upd_upper_c;
    end
`endif
  end

  // Table, valid, PLRU state and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      upper_tbl              <= '{default: '0};
      valid                  <= '0;
      plru                   <= '0;
      read_upper_PC          <= '0;
      update1_upper_PC_index <= '0;
    end else begin
      if (read_valid) begin
        read_upper_PC <= rd_data_c;
      end
      if (update0_valid) begin
        update1_upper_PC_index <= upd_idx_c;
        if (!upd_hit_c) begin
          upper_tbl[upd_idx_c] <= upd_upper_c;
          valid[upd_idx_c]     <= 1'b1;
        end
      end
      plru <= plru_next_c;
    end
  end

endmodule

// File: tb/tb_upct.sv
// Bench for upct: recency-based model of the table plus directed literal checks.
module tb_upct;
  import core_types_pkg::*;

  localparam int N = int'(UPPER_PC_TABLE_ENTRIES);
`ifdef UPCT_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        read_valid;
  upct_idx_t   read_index;
  upper_PC_t   read_upper_PC;
  logic        update0_valid;
  logic [31:0] update0_target_full_PC;
  upct_idx_t   update1_upper_PC_index;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  upct dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .read_valid             (read_valid),
    .read_index             (read_index),
    .read_upper_PC          (read_upper_PC),
    .update0_valid          (update0_valid),
    .update0_target_full_PC (update0_target_full_PC),
    .update1_upper_PC_index (update1_upper_PC_index)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: contents, valid flags and the time each entry was last touched.
  upper_PC_t m_arr [N];
  bit        m_val [N];
  longint    m_t   [N];
  longint    stamp;
  upper_PC_t exp_rd;
  upct_idx_t exp_ui;
  upper_PC_t nu;
  int        ui;

  // Tree PLRU as recency: at each split go toward the half whose newest touch is older.
  function automatic int victim_of();
    int lo = 0;
    int sz = N;
    while (sz > 1) begin
      int half = sz / 2;
      longint ml = -1;
      longint mr = -1;
      for (int i = lo; i < lo + half; i++) if (m_t[i] > ml) ml = m_t[i];
      for (int i = lo + half; i < lo + sz; i++) if (m_t[i] > mr) mr = m_t[i];
      if (ml > mr) lo = lo + half;
      sz = half;
    end
    return lo;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        m_arr[i] = '0;
        m_val[i] = 1'b0;
        m_t[i]   = -1;
      end
      stamp  = 0;
      exp_rd = '0;
      exp_ui = '0;
    end else begin
      if (read_valid) begin
        exp_rd = m_arr[read_index];
        m_t[read_index] = stamp;
        stamp++;
      end
      if (update0_valid) begin
        nu = update0_target_full_PC[31:11];
        ui = -1;
        for (int i = N - 1; i >= 0; i--) if (m_val[i] && m_arr[i] == nu) ui = i;
        if (ui < 0) begin
          for (int i = N - 1; i >= 0; i--) if (!m_val[i]) ui = i;
          if (ui < 0) ui = victim_of();
          if (BYPASS && read_valid && ui == int'(read_index)) exp_rd = nu;
          m_arr[ui] = nu;
          m_val[ui] = 1'b1;
        end
        exp_ui = upct_idx_t'(ui);
        m_t[ui] = stamp;
        stamp++;
      end
    end
  end

  // Continuous compare on the falling edge.
  always @(negedge CLK) begin
    chk("model_read_upper_PC", 32'(read_upper_PC), 32'(exp_rd));
    chk("model_update1_index", 32'(update1_upper_PC_index), 32'(exp_ui));
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic upd(input logic [31:0] pc);
    update0_valid          = 1'b1;
    update0_target_full_PC = pc;
    step();
    update0_valid = 1'b0;
  endtask

  task automatic rd(input int idx);
    read_valid = 1'b1;
    read_index = upct_idx_t'(idx);
    step();
    read_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("reset_read_upper_PC", 32'(read_upper_PC), 32'h0);
    chk("reset_update1_index", 32'(update1_upper_PC_index), 32'h0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] exp_tbl [8];

  initial begin : stim
    read_valid             = 1'b0;
    read_index             = '0;
    update0_valid          = 1'b0;
    update0_target_full_PC = '0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("post_reset_read", 32'(read_upper_PC), 32'h0);
    chk("post_reset_index", 32'(update1_upper_PC_index), 32'h0);

    // First allocation and read back.
    upd(32'h0000_0800);
    chk("first_alloc_idx", 32'(update1_upper_PC_index), 32'h0);
    step();
    rd(0);
    chk("first_read", 32'(read_upper_PC), 32'h000001);

    // Fill the table in order; k=0 hits the existing entry.
    for (int k = 0; k < 8; k++) begin
      upd(32'h0000_0800 + 32'(k) * 32'h800);
      chk("fill_idx", 32'(update1_upper_PC_index), 32'(k));
    end
    upd(32'h0000_1000);
    chk("repeat_hit_idx", 32'(update1_upper_PC_index), 32'h1);
    for (int k = 0; k < 8; k++) begin
      rd(k);
      chk("fill_contents", 32'(read_upper_PC), 32'(k + 1));
    end

    // Touch all but entry 7 in an order that leaves 7 as the tree victim.
    rd(6); rd(4); rd(5); rd(0); rd(1); rd(2); rd(3);
    upd(32'hFFFF_F800);
    chk("plru_victim_idx", 32'(update1_upper_PC_index), 32'h7);
    rd(7);
    chk("plru_victim_read", 32'(read_upper_PC), 32'h1FFFFF);

    // Same new PC on consecutive cycles: one allocation (victim 0), then a hit.
    update0_valid          = 1'b1;
    update0_target_full_PC = 32'hABCD_E800;
    step();
    chk("b2b_first_idx", 32'(update1_upper_PC_index), 32'h0);
    step();
    chk("b2b_second_idx", 32'(update1_upper_PC_index), 32'h0);
    update0_valid = 1'b0;
    exp_tbl[0] = 32'h1579BD; exp_tbl[1] = 32'h2; exp_tbl[2] = 32'h3; exp_tbl[3] = 32'h4;
    exp_tbl[4] = 32'h5;      exp_tbl[5] = 32'h6; exp_tbl[6] = 32'h7; exp_tbl[7] = 32'h1FFFFF;
    for (int k = 0; k < 8; k++) begin
      rd(k);
      chk("b2b_contents", 32'(read_upper_PC), exp_tbl[k]);
    end

    // Read of the entry being allocated in the same cycle.
    do_reset();
    upd(32'h0000_0800);
    upd(32'h0000_1000);
    upd(32'h0000_1800);
    chk("prefill_idx", 32'(update1_upper_PC_index), 32'h2);
    read_valid             = 1'b1;
    read_index             = upct_idx_t'(3);
    update0_valid          = 1'b1;
    update0_target_full_PC = 32'h055E_6800;
    step();
    read_valid    = 1'b0;
    update0_valid = 1'b0;
    chk("collide_idx", 32'(update1_upper_PC_index), 32'h3);
    chk("collide_read", 32'(read_upper_PC), BYPASS ? 32'h00ABCD : 32'h0);
    rd(3);
    chk("collide_readback", 32'(read_upper_PC), 32'h00ABCD);

    // Reset with an update result pending.
    upd(32'h0000_2000);
    chk("pending_idx", 32'(update1_upper_PC_index), 32'h4);
    do_reset();
    upd(32'h0000_2000);
    chk("realloc_idx", 32'(update1_upper_PC_index), 32'h0);
    rd(0);
    chk("realloc_read", 32'(read_upper_PC), 32'h4);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
